// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, reset PC and the fetch queue entry type.
package fetch_pkg;
    localparam int BITS = 32;
    localparam logic [BITS-1:0] RESET_PC = 32'h0000_0000;
    localparam int INSTR_BYTES = 4;
    localparam int FIFO_DEPTH = 2;
    typedef struct packed {
        logic [BITS-1:0] pc;
        logic [BITS-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: 2-entry shift queue of fetched {pc, instr}; head always sits in slot 0.
module fetch_fifo
#(
    parameter type T = fetch_pkg::fetch_entry_t
)(
    input  logic       clk,
    input  logic       flush,
    input  logic       push,
    input  logic       pop,
    input  T           din,
    output T           head,
    output logic [1:0] count
);
    import fetch_pkg::*;
    T mem [FIFO_DEPTH];
    logic do_pop, do_push;
    logic [1:0] slot;
    assign do_pop  = pop && count != 2'd0;
    assign do_push = push && (count != 2'd2 || do_pop);
    assign slot    = count - {1'b0, do_pop};
    assign head    = mem[0];
    always_ff @(posedge clk) begin
        if (flush) begin
            count <= 2'd0;
        end else begin
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
            if (do_pop) mem[0] <= mem[1];
            // slot is where the new entry lands after any shift from the pop
            if (do_push) mem[slot[0]] <= din;
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC generation, 1-cycle memory fetch and a 2-entry decode queue.
// FETCH_PERF_CNT_EN adds saturating fetch_count/stall_count outputs.
module fetch_unit
#(
    parameter int              BITS     = fetch_pkg::BITS,
    parameter logic [BITS-1:0] RESET_PC = fetch_pkg::RESET_PC
)(
    input  logic            clk,
    input  logic            reset,
    output logic [BITS-1:0] pc_addr,
    input  logic [BITS-1:0] mem_instr,
    input  logic            redirect_valid,
    input  logic [BITS-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] out_instr,
    output logic [BITS-1:0] out_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     fetch_count,
    output logic [31:0]     stall_count
`endif
);
    import fetch_pkg::*;
    typedef struct packed {
        logic [BITS-1:0] pc;
        logic [BITS-1:0] instr;
    } entry_t;
    logic [BITS-1:0] pc, req_pc;
    logic pending, pop, issue, flush;
    logic [1:0] count;
    logic [2:0] occupancy;
    entry_t head, din;
    assign pop       = out_valid && out_ready;
    // slots committed after this edge: queued + in flight - leaving
    assign occupancy = {1'b0, count} + {2'b0, pending} - {2'b0, pop};
    assign issue     = !redirect_valid && occupancy < 3'd2;
    assign flush     = !reset || redirect_valid;
    assign din       = '{pc: req_pc, instr: mem_instr};
    assign pc_addr   = pc;
    assign out_valid = count != 2'd0;
    assign out_instr = head.instr;
    assign out_pc    = head.pc;
    fetch_fifo #(.T(entry_t)) u_fifo (
        .clk   (clk),
        .flush (flush),
        .push  (pending),
        .pop   (pop),
        .din   (din),
        .head  (head),
        .count (count)
    );
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc      <= RESET_PC;
            req_pc  <= RESET_PC;
            pending <= 1'b0;
        end else if (redirect_valid) begin
            pc      <= {redirect_pc[BITS-1:2], 2'b00};
            pending <= 1'b0;
        end else if (issue) begin
            pc      <= pc + BITS'(INSTR_BYTES);
            req_pc  <= pc;
            pending <= 1'b1;
        end else begin
            pending <= 1'b0;
        end
    end
`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else begin
            if (pop && fetch_count != '1) fetch_count <= fetch_count + 32'd1;
            if (out_valid && !out_ready && stall_count != '1) stall_count <= stall_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit streaming, stalls, redirects, reset and PC wrap.
module tb_fetch_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset, redirect_valid, out_ready, out_valid;
    logic [31:0] redirect_pc, pc_addr, mem_instr, out_instr, out_pc;
    logic reset2, out_ready2, out_valid2;
    logic redirect_valid2 = 1'b0;
    logic [31:0] redirect_pc2 = 32'h0;
    logic [31:0] pc_addr2, mem_instr2, out_instr2, out_pc2;
    int checks = 0;
    int errors = 0;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count, stall_count, fetch_count2, stall_count2;
`endif

    fetch_unit dut (
        .clk(clk), .reset(reset), .pc_addr(pc_addr), .mem_instr(mem_instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
    );

    fetch_unit #(.BITS(32), .RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .reset(reset2), .pc_addr(pc_addr2), .mem_instr(mem_instr2),
        .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_instr(out_instr2), .out_pc(out_pc2)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_count(fetch_count2), .stall_count(stall_count2)
`endif
    );

    // instruction memory: word[i] = i, one cycle read latency
    always @(posedge clk) begin
        mem_instr  <= pc_addr >> 2;
        mem_instr2 <= pc_addr2 >> 2;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0500;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
        checks++;
        if (pc_addr !== 32'h0) begin errors++; $display("FAIL reset_pc_addr got %h want 00000000", pc_addr); end
    endtask

    task automatic test_stream();
        reset = 1'b1;
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_e0_valid got %0b want 0", out_valid); end
        checks++;
        if (pc_addr !== 32'h4) begin errors++; $display("FAIL stream_e0_pc_addr got %h want 00000004", pc_addr); end
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'(4 * i) || out_instr !== 32'(i)) begin
                errors++;
                $display("FAIL stream_%0d got v=%0b pc=%h instr=%h want v=1 pc=%h instr=%h", i, out_valid, out_pc, out_instr, 32'(4 * i), 32'(i));
            end
            tick();
        end
    endtask

    task automatic test_stall();
        reset = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_reset_valid got %0b want 0", out_valid); end
        reset = 1'b1;
        out_ready = 1'b0;
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
                errors++;
                $display("FAIL stall_hold_%0d got v=%0b pc=%h want v=1 pc=00000000", k, out_valid, out_pc);
            end
            tick();
        end
        checks++;
        if (pc_addr !== 32'h8) begin errors++; $display("FAIL stall_pc_addr got %h want 00000008", pc_addr); end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'(4 * k) || out_instr !== 32'(k)) begin
                errors++;
                $display("FAIL stall_release_%0d got v=%0b pc=%h instr=%h want v=1 pc=%h instr=%h", k, out_valid, out_pc, out_instr, 32'(4 * k), 32'(k));
            end
            tick();
        end
    endtask

    task automatic test_redirect();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0103;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || pc_addr !== 32'h100) begin
            errors++;
            $display("FAIL redir_e got v=%0b pc_addr=%h want v=0 pc_addr=00000100", out_valid, pc_addr);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_e1_valid got %0b want 0", out_valid); end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_instr !== 32'h40) begin
            errors++;
            $display("FAIL redir_e2 got v=%0b pc=%h instr=%h want v=1 pc=00000100 instr=00000040", out_valid, out_pc, out_instr);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h104 || out_instr !== 32'h41) begin
            errors++;
            $display("FAIL redir_next got v=%0b pc=%h instr=%h want v=1 pc=00000104 instr=00000041", out_valid, out_pc, out_instr);
        end
    endtask

    task automatic test_back_to_back();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0200;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_first_valid got %0b want 0", out_valid); end
        redirect_pc = 32'h0000_0300;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || pc_addr !== 32'h300) begin
            errors++;
            $display("FAIL b2b_second got v=%0b pc_addr=%h want v=0 pc_addr=00000300", out_valid, pc_addr);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_e1_valid got %0b want 0", out_valid); end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h300 || out_instr !== 32'hC0) begin
            errors++;
            $display("FAIL b2b_target got v=%0b pc=%h instr=%h want v=1 pc=00000300 instr=000000c0", out_valid, out_pc, out_instr);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        repeat (3) tick();
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_full_valid got %0b want 1", out_valid); end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || pc_addr !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset got v=%0b pc_addr=%h want v=0 pc_addr=00000000", out_valid, pc_addr);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_e0_valid got %0b want 0", out_valid); end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h0) begin
            errors++;
            $display("FAIL mid_restart got v=%0b pc=%h instr=%h want v=1 pc=00000000 instr=00000000", out_valid, out_pc, out_instr);
        end
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        out_ready = 1'b0;
        tick();
        tick();
        repeat (3) tick();
        out_ready = 1'b1;
        repeat (10) tick();
        checks++;
        if (fetch_count !== 32'd10 || stall_count !== 32'd3) begin
            errors++;
            $display("FAIL perf got fetch=%0d stall=%0d want fetch=10 stall=3", fetch_count, stall_count);
        end
    endtask
`endif

    task automatic test_wrap();
        checks++;
        if (pc_addr2 !== 32'hFFFF_FFF8 || out_valid2 !== 1'b0) begin
            errors++;
            $display("FAIL wrap_reset got v=%0b pc_addr=%h want v=0 pc_addr=fffffff8", out_valid2, pc_addr2);
        end
        reset2 = 1'b1;
        tick();
        tick();
        checks++;
        if (out_valid2 !== 1'b1 || out_pc2 !== 32'hFFFF_FFF8 || out_instr2 !== 32'h3FFF_FFFE) begin
            errors++;
            $display("FAIL wrap_0 got v=%0b pc=%h instr=%h want v=1 pc=fffffff8 instr=3ffffffe", out_valid2, out_pc2, out_instr2);
        end
        tick();
        checks++;
        if (out_valid2 !== 1'b1 || out_pc2 !== 32'hFFFF_FFFC || out_instr2 !== 32'h3FFF_FFFF) begin
            errors++;
            $display("FAIL wrap_1 got v=%0b pc=%h instr=%h want v=1 pc=fffffffc instr=3fffffff", out_valid2, out_pc2, out_instr2);
        end
        tick();
        checks++;
        if (out_valid2 !== 1'b1 || out_pc2 !== 32'h0 || out_instr2 !== 32'h0) begin
            errors++;
            $display("FAIL wrap_2 got v=%0b pc=%h instr=%h want v=1 pc=00000000 instr=00000000", out_valid2, out_pc2, out_instr2);
        end
    endtask

    initial begin
        reset = 1'b0;
        reset2 = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        out_ready = 1'b1;
        out_ready2 = 1'b1;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_back_to_back();
        test_reset_mid();
`ifdef FETCH_PERF_CNT_EN
        test_perf();
`endif
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameters SHALL be: BITS, default 32, address/instruction width; RESET_PC, default 32'h0000_0000, PC after reset.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low; state cleared on any rising clk edge sampling reset=0.
REQ-004 pc_addr  output  BITS  word address driven to InstructionMemory, equals current PC register.
REQ-005 mem_instr  input  BITS  InstructionMemory read data; valid in the cycle after the edge that sampled pc_addr.
REQ-006 redirect_valid  input  1  branch/jump redirect request, sampled on rising edge.
REQ-007 redirect_pc  input  BITS  redirect target.
REQ-008 out_valid  output  1  instruction available to decode.
REQ-009 out_ready  input  1  decode accepts; transfer occurs on an edge with out_valid=1 and out_ready=1.
REQ-010 out_instr  output  BITS  instruction at FIFO head.
REQ-011 out_pc  output  BITS  PC of out_instr.

Function
REQ-012 Request issue: at each edge with reset=1, no redirect, and (fifo_count + pending - pop) < 2, the unit SHALL set pending=1 and PC <= PC + 4; otherwise pending <= 0 and PC holds.
REQ-013 PC arithmetic SHALL be modulo 2^BITS; 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000.
REQ-014 When pending=1 at an edge, {PC of that request, mem_instr} SHALL be written to the 2-entry FIFO at that edge (1-cycle fetch latency).
REQ-015 FIFO SHALL never overflow; issue rule of REQ-012 guarantees space; simultaneous push and pop at count=2 SHALL keep count=2.
REQ-016 out_valid SHALL equal (fifo_count != 0); out_instr/out_pc SHALL show the head entry and stay stable while out_valid=1 and out_ready=0.
REQ-017 Redirect at edge E: PC <= {redirect_pc[BITS-1:2], 2'b00}, FIFO emptied, pending <= 0; out_valid=0 after E; first target instruction issued at E+1, out_valid=1 after E+2.
REQ-018 Redirect SHALL take priority over issue and over a simultaneous pop; a head entry handshaken at E counts as consumed.
REQ-019 Back-to-back redirects SHALL each restart REQ-017 timing; only the last target is fetched.
REQ-020 With out_ready held 1, steady-state throughput SHALL be one instruction per cycle in ascending PC order.

Reset
REQ-021 During reset: PC=RESET_PC, pending=0, FIFO empty, out_valid=0, pc_addr=RESET_PC; redirect_valid ignored.
REQ-022 First edge sampling reset=1 (E0) SHALL issue RESET_PC; out_valid=1, out_pc=RESET_PC after E1.
REQ-023 Reset asserted mid-operation SHALL discard FIFO and pending request at that edge.

Configuration
REQ-024 Macro FETCH_PERF_CNT_EN defined: outputs fetch_count (32) and stall_count (32) SHALL exist; fetch_count +1 per out handshake, stall_count +1 per cycle with out_valid=1 and out_ready=0; both saturate at 32'hFFFF_FFFF, cleared by reset.
REQ-025 Macro undefined: those ports and counters SHALL be absent; all other behaviour identical.

Structure
REQ-026 Package fetch_pkg SHALL hold BITS, RESET_PC default, INSTR_BYTES=4, FIFO_DEPTH=2, and typedef fetch_entry_t {pc, instr}.
REQ-027 FIFO SHALL be sub-module fetch_fifo (depth 2, fetch_entry_t, push/pop/flush/count); fetch_unit holds PC, pending and issue logic.

Verification
REQ-028 Reset low 2 cycles, release, out_ready=1, memory word[i]=i -> handshakes out_pc 0,4,8,12,16 with out_instr 0,1,2,3,4 on consecutive cycles from E1.
REQ-029 out_ready=0 for 5 cycles after first valid -> out_pc stays 0, pc_addr stops at 8, FIFO holds 0 and 4; release -> 0,4,8 delivered, no drop/duplicate.
REQ-030 redirect_valid=1, redirect_pc=32'h0000_0103 during streaming -> out_valid=0 next 2 cycles, next out_pc=32'h0000_0100; no stale PC delivered.
REQ-031 RESET_PC=32'hFFFF_FFF8, out_ready=1 -> out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-032 reset=0 for one cycle while FIFO full -> out_valid=0 after that edge; restart from RESET_PC per REQ-022.
REQ-033 With FETCH_PERF_CNT_EN, 10 handshakes and 3 stall cycles -> fetch_count=10, stall_count=3.
